// File: rtl/booth_radix4_seq_mult.sv
// Iterative radix-4 Booth multiplier. Each clock retires one Booth digit into
// a 2*WIDTH-bit accumulator. Operands enter and the product leaves through
// valid/ready handshakes.
module booth_radix4_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int DIGITS = WIDTH / 2 + 1;
    localparam int PW     = 2 * WIDTH;
    localparam int YW     = WIDTH + 3;
    localparam int CW     = $clog2(DIGITS);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
        $error("booth_radix4_seq_mult: WIDTH must be even and at least 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   acc_q, m_q, product_q;
    logic [YW-1:0]   y_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   a_ext, m2, addend, acc_sum;
    logic [YW-1:0]   b_ext;

    // Extension is resolved at acceptance, so signed_mode needs no register.
    // y carries an implicit Y[-1] = 0 in its bit 0.
    assign a_ext = {{(PW - WIDTH){signed_mode & a[WIDTH-1]}}, a};
    assign b_ext = {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;

    // m_q is pre-shifted by 2i, so the addend already has its digit weight.
    assign m2 = m_q << 1;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        addend = '0;
        unique case (y_q[2:0])
            3'b001, 3'b010: addend = m_q;
            3'b011:         addend = m2;
            3'b100:         addend = ~m2 + PW'(1);
            3'b101, 3'b110: addend = ~m_q + PW'(1);
            default:        addend = '0;
        endcase
    end

    assign acc_sum = acc_q + addend;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (cnt_q == LAST_DIGIT) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            m_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        m_q   <= a_ext;
                        y_q   <= b_ext;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                CALC: begin
                    acc_q <= acc_sum;
                    m_q   <= m_q << 2;
                    y_q   <= y_q >> 2;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_DIGIT) product_q <= acc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Bench for booth_radix4_seq_mult at WIDTH=8 and WIDTH=16. Drivers push expected
// products into queues; per-instance monitors pop and compare on each output handshake.
module tb_booth_radix4_seq_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        v8 = 1'b0, sm8 = 1'b0, ordy8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        rdy8, ov8;
    logic [15:0] p8;

    logic        v16 = 1'b0, sm16 = 1'b0, ordy16;
    logic [15:0] a16 = '0, b16 = '0;
    logic        rdy16, ov16;
    logic [31:0] p16;

    int checks = 0;
    int errors = 0;
    bit rand_bp = 1'b0;

    logic [15:0] exp8_q[$];
    logic [31:0] exp16_q[$];

    always #5 clk = ~clk;

    booth_radix4_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
        .signed_mode(sm8), .out_valid(ov8), .out_ready(ordy8), .product(p8)
    );

    booth_radix4_seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16),
        .signed_mode(sm16), .out_valid(ov16), .out_ready(ordy16), .product(p16)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic s);
        logic [31:0] xe, ye;
        xe = s ? {{16{x[15]}}, x} : {16'b0, x};
        ye = s ? {{16{y[15]}}, y} : {16'b0, y};
        return xe * ye;
    endfunction

    // Monitors: compare at the falling edge preceding each output handshake.
    initial forever begin
        @(negedge clk);
        if (rst_n && ov8 && ordy8) begin
            if (exp8_q.size() == 0) check("unexpected_out8", 32'(exp8_q.size()), 32'd1);
            else                    check("product8", {16'b0, p8}, {16'b0, exp8_q.pop_front()});
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && ov16 && ordy16) begin
            if (exp16_q.size() == 0) check("unexpected_out16", 32'(exp16_q.size()), 32'd1);
            else                     check("product16", p16, exp16_q.pop_front());
        end
    end

    // Downstream readiness for the 16-bit instance; random stalls when enabled.
    initial begin
        ordy16 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ordy16 = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ism,
                          input logic [15:0] exp, input bit push);
        int n = 0;
        @(negedge clk);
        a8 = ia; b8 = ib; sm8 = ism; v8 = 1'b1;
        while (!rdy8 && n < 200) begin @(negedge clk); n++; end
        check("accept8", {31'b0, rdy8}, 32'd1);
        @(posedge clk);
        if (push) exp8_q.push_back(exp);
        #1 v8 = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] ia, input logic [15:0] ib, input logic ism,
                           input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        a16 = ia; b16 = ib; sm16 = ism; v16 = 1'b1;
        while (!rdy16 && n < 400) begin @(negedge clk); n++; end
        check("accept16", {31'b0, rdy16}, 32'd1);
        @(posedge clk);
        exp16_q.push_back(exp);
        #1 v16 = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while ((exp8_q.size() != 0 || ov8) && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        check("drain8", 32'(exp8_q.size()), 32'd0);
    endtask

    task automatic drain16();
        int n = 0;
        while ((exp16_q.size() != 0 || ov16) && n < 400) begin @(negedge clk); n++; end
        @(negedge clk);
        check("drain16", 32'(exp16_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec8_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] p;
    } vec16_t;

    vec8_t vecs8[$] = '{
        '{8'h80, 8'h80, 1'b1, 16'h4000},
        '{8'h80, 8'h7F, 1'b1, 16'hC080},
        '{8'hAA, 8'h55, 1'b0, 16'h3872},
        '{8'h00, 8'h7B, 1'b0, 16'h0000},
        '{8'hFF, 8'h00, 1'b1, 16'h0000},
        '{8'hFF, 8'hFF, 1'b1, 16'h0001},
        '{8'h80, 8'h02, 1'b0, 16'h0100},
        '{8'h7F, 8'h7F, 1'b1, 16'h3F01},
        '{8'hFF, 8'h80, 1'b1, 16'h0080}
    };

    vec16_t vecs16[$] = '{
        '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000},
        '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001},
        '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001},
        '{16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000},
        '{16'h0000, 16'hBEEF, 1'b1, 32'h0000_0000}
    };

    initial begin
        int n;
        logic [15:0] ra, rb;
        logic        rs;

        // Reset state, sampled while reset is held and just after release.
        #12;
        check("rst_out_valid8", {31'b0, ov8}, 32'd0);
        check("rst_product8", {16'b0, p8}, 32'd0);
        check("rst_product16", p16, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready8", {31'b0, rdy8}, 32'd1);
        check("rst_in_ready16", {31'b0, rdy16}, 32'd1);

        // Unsigned all-ones with latency measurement.
        issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ov8 && n < 20);
        check("latency8", 32'(n), 32'd5);
        drain8();

        foreach (vecs8[i]) issue8(vecs8[i].a, vecs8[i].b, vecs8[i].s, vecs8[i].p, 1'b1);
        drain8();

        // Backpressure: product held for 10 cycles, then a one-cycle out_ready pulse.
        ordy8 = 1'b0;
        issue8(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b1);
        n = 0;
        while (!ov8 && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid8", {31'b0, ov8}, 32'd1);
            check("bp_product8", {16'b0, p8}, 32'h03A8);
            check("bp_in_ready8", {31'b0, rdy8}, 32'd0);
        end
        ordy8 = 1'b1;
        @(posedge clk); #1;
        ordy8 = 1'b0;
        check("bp_release_valid8", {31'b0, ov8}, 32'd0);
        check("bp_release_ready8", {31'b0, rdy8}, 32'd1);
        check("bp_product_kept8", {16'b0, p8}, 32'h03A8);
        ordy8 = 1'b1;
        drain8();

        // Reset two cycles into CALC aborts the transaction asynchronously.
        issue8(8'h0F, 8'h0F, 1'b0, 16'h0000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid8", {31'b0, ov8}, 32'd0);
        check("abort_product8", {16'b0, p8}, 32'd0);
        check("abort_in_ready8", {31'b0, rdy8}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue8(8'h03, 8'h05, 1'b0, 16'h000F, 1'b1);
        drain8();

        // Operands changed during CALC are ignored, then accepted after the handshake.
        issue8(8'h85, 8'h13, 1'b1, 16'hF6DF, 1'b1);
        a8 = 8'h11; b8 = 8'h22; sm8 = 1'b0; v8 = 1'b1;
        exp8_q.push_back(16'h0242);
        n = 0;
        while (!rdy8 && n < 100) begin @(negedge clk); n++; end
        check("held_accept_gap8", 32'(n), 32'd7);
        @(posedge clk);
        #1 v8 = 1'b0;
        drain8();

        // WIDTH=16 directed boundary cases.
        foreach (vecs16[i]) issue16(vecs16[i].a, vecs16[i].b, vecs16[i].s, vecs16[i].p);
        drain16();

        // WIDTH=16 random operands and modes with random output stalls.
        rand_bp = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            issue16(ra, rb, rs, model16(ra, rb, rs));
        end
        rand_bp = 1'b0;
        drain16();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
